// File: rtl/vl_systest_pkg.sv
// Shared types and helpers for the VL systest compare benches.
package vl_systest_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MODE_APPROX = 0;
  localparam int MODE_STRICT = 1;

  localparam logic [15:0] SAT_MAX16 = 16'hFFFF;

  // Increment that sticks at the 16-bit ceiling instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == SAT_MAX16) ? value : value + 16'd1;
  endfunction

  // True only for an X bit; a Z bit is deliberately not treated as "don't care".
  function automatic logic is_x_bit(input logic b);
    return $isunknown(b) && (b !== 1'bz);
  endfunction

endpackage

// File: rtl/lane_approx_check.sv
// One impl/spec lane comparator; raises fail when any bit does not match.
module lane_approx_check
  import vl_systest_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = MODE_APPROX
) (
  input  logic [WIDTH-1:0] impl,
  input  logic [WIDTH-1:0] spec,
  output logic             fail
);

  logic [WIDTH-1:0] bit_ok;

  // Strict mode needs exact four-valued equality; approximate mode lets an
  // X on the impl side stand in for whatever the spec side holds.
  always_comb begin
    bit_ok = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (MODE == MODE_STRICT) begin
        bit_ok[b] = (impl[b] === spec[b]);
      end else begin
        bit_ok[b] = (impl[b] === spec[b]) || is_x_bit(impl[b]);
      end
    end
  end

  assign fail = ~&bit_ok;

endmodule

// File: rtl/approx_compare_monitor.sv
// Clocked equivalence monitor: checks CHANNELS impl/spec lanes per sample,
// counts checks, failures and skipped samples, and records the first failure.
module approx_compare_monitor
  import vl_systest_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CHANNELS     = 8,
  parameter int SWIDTH       = 24,
  parameter int MODE         = MODE_APPROX,
  parameter int SKIP_XZ_STIM = 1,
  localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [31:0]               num_checks,
  input  logic                      sample,
  input  logic [SWIDTH-1:0]         stim,
  input  logic [CHANNELS*WIDTH-1:0] impl,
  input  logic [CHANNELS*WIDTH-1:0] spec,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [31:0]               checks_done,
  output logic [15:0]               fail_count,
  output logic [15:0]               skip_count,
  output logic                      first_fail_valid,
  output logic [CW-1:0]             first_fail_chan,
  output logic [31:0]               first_fail_index
);

  state_t              state;
  state_t              state_next;
  logic [31:0]         target;
  logic [CHANNELS-1:0] lane_fail;
  logic [CW-1:0]       low_chan;
  logic                stim_xz;
  logic                launch;
  logic                accept;
  logic                final_sample;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    lane_approx_check #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_lane (
      .impl (impl[c*WIDTH +: WIDTH]),
      .spec (spec[c*WIDTH +: WIDTH]),
      .fail (lane_fail[c])
    );
  end

  // Flag samples whose stimulus is not fully known, when skipping is enabled.
  always_comb begin
    stim_xz = (SKIP_XZ_STIM != 0) && $isunknown(stim);
  end

  // Priority encoder: scanning downwards leaves the lowest failing lane.
  always_comb begin
    low_chan = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (lane_fail[c]) begin
        low_chan = CW'(c);
      end
    end
  end

  // Qualified events: a start only counts outside RUN, a sample only inside it.
  always_comb begin
    launch       = start && ((state == IDLE) || (state == DONE));
    accept       = (state == RUN) && sample;
    final_sample = accept && ((checks_done + 32'd1) == target);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DONE only leaves via a new start or reset.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (num_checks == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (final_sample) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are decoded from registered state only.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    pass = (state == DONE) && (fail_count == 16'd0);
  end

  // Counters and first-failure capture; a start wipes the previous run.
  always_ff @(posedge clk) begin
    if (reset) begin
      target           <= '0;
      checks_done      <= '0;
      fail_count       <= '0;
      skip_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_chan  <= '0;
      first_fail_index <= '0;
    end else if (launch) begin
      target           <= num_checks;
      checks_done      <= '0;
      fail_count       <= '0;
      skip_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_chan  <= '0;
      first_fail_index <= '0;
    end else if (accept) begin
      checks_done <= checks_done + 32'd1;
      if (stim_xz) begin
        skip_count <= sat_inc16(skip_count);
      end else if (|lane_fail) begin
        fail_count <= sat_inc16(fail_count);
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_chan  <= low_chan;
          first_fail_index <= checks_done;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_compare_monitor.sv
// Scoreboard bench: an approximate and a strict monitor share the same inputs
// and are compared against a behavioural model of both.
module tb_approx_compare_monitor;

  localparam int W  = 4;
  localparam int CH = 2;
  localparam int SW = 24;

  typedef struct packed {
    logic [31:0] cd;
    logic [15:0] fc;
    logic [15:0] sc;
    logic        ffv;
    logic        ffc;
    logic [31:0] ffi;
  } model_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          sample = 1'b0;
  logic [31:0]   num_checks = '0;
  logic [SW-1:0] stim = '0;
  logic [CH*W-1:0] impl = '0;
  logic [CH*W-1:0] spec = '0;

  logic a_busy, a_done, a_pass, a_ffv;
  logic s_busy, s_done, s_pass, s_ffv;
  logic [31:0] a_cd, a_ffi, s_cd, s_ffi;
  logic [15:0] a_fc, a_sc, s_fc, s_sc;
  logic [0:0]  a_ffc, s_ffc;

  model_t obs_a, obs_s;
  model_t m [2];
  model_t q_a [$];
  model_t q_s [$];
  int     ms;
  logic [31:0] mtarget;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  approx_compare_monitor #(
    .WIDTH(W), .CHANNELS(CH), .SWIDTH(SW), .MODE(0), .SKIP_XZ_STIM(1)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .num_checks(num_checks),
    .sample(sample), .stim(stim), .impl(impl), .spec(spec),
    .busy(a_busy), .done(a_done), .pass(a_pass), .checks_done(a_cd),
    .fail_count(a_fc), .skip_count(a_sc), .first_fail_valid(a_ffv),
    .first_fail_chan(a_ffc), .first_fail_index(a_ffi)
  );

  approx_compare_monitor #(
    .WIDTH(W), .CHANNELS(CH), .SWIDTH(SW), .MODE(1), .SKIP_XZ_STIM(1)
  ) dut_s (
    .clk(clk), .reset(reset), .start(start), .num_checks(num_checks),
    .sample(sample), .stim(stim), .impl(impl), .spec(spec),
    .busy(s_busy), .done(s_done), .pass(s_pass), .checks_done(s_cd),
    .fail_count(s_fc), .skip_count(s_sc), .first_fail_valid(s_ffv),
    .first_fail_chan(s_ffc), .first_fail_index(s_ffi)
  );

  assign obs_a = {a_cd, a_fc, a_sc, a_ffv, a_ffc, a_ffi};
  assign obs_s = {s_cd, s_fc, s_sc, s_ffv, s_ffc, s_ffi};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic bit bitMatch(input logic i, input logic s, input int mode);
    if (i === s) return 1'b1;
    if (mode == 0 && $isunknown(i) && (i !== 1'bz)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit laneFails(input logic [W-1:0] i, input logic [W-1:0] s, input int mode);
    for (int b = 0; b < W; b++) begin
      if (!bitMatch(i[b], s[b], mode)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic clearModel();
    for (int k = 0; k < 2; k++) m[k] = '0;
  endtask

  task automatic modelSample(input logic [SW-1:0] st, input logic [CH*W-1:0] im, input logic [CH*W-1:0] sp);
    int lowest;
    if (ms != 1) return;
    for (int k = 0; k < 2; k++) begin
      if ($isunknown(st)) begin
        m[k].sc = sat16(m[k].sc);
      end else begin
        lowest = -1;
        for (int c = 0; c < CH; c++) begin
          if (lowest < 0 && laneFails(im[c*W +: W], sp[c*W +: W], k)) lowest = c;
        end
        if (lowest >= 0) begin
          m[k].fc = sat16(m[k].fc);
          if (!m[k].ffv) begin
            m[k].ffv = 1'b1;
            m[k].ffc = 1'(lowest);
            m[k].ffi = m[k].cd;
          end
        end
      end
      m[k].cd = m[k].cd + 32'd1;
    end
    if (m[0].cd == mtarget) begin
      q_a.push_back(m[0]);
      q_s.push_back(m[1]);
      ms = 2;
    end
  endtask

  task automatic compareSet(input string tag, input int k, input model_t e,
                            input logic eb, input logic ed, input logic ep);
    model_t o;
    string  p;
    o = (k == 0) ? obs_a : obs_s;
    p = (k == 0) ? {tag, "/A"} : {tag, "/S"};
    checkOutput({p, "/busy"}, 32'((k == 0) ? a_busy : s_busy), 32'(eb));
    checkOutput({p, "/done"}, 32'((k == 0) ? a_done : s_done), 32'(ed));
    checkOutput({p, "/pass"}, 32'((k == 0) ? a_pass : s_pass), 32'(ep));
    checkOutput({p, "/checks_done"}, o.cd, e.cd);
    checkOutput({p, "/fail_count"}, 32'(o.fc), 32'(e.fc));
    checkOutput({p, "/skip_count"}, 32'(o.sc), 32'(e.sc));
    checkOutput({p, "/ff_valid"}, 32'(o.ffv), 32'(e.ffv));
    checkOutput({p, "/ff_chan"}, 32'(o.ffc), 32'(e.ffc));
    checkOutput({p, "/ff_index"}, o.ffi, e.ffi);
  endtask

  task automatic verifyNow(input string tag);
    for (int k = 0; k < 2; k++) begin
      compareSet(tag, k, m[k], ms == 1, ms == 2, (ms == 2) && (m[k].fc == 16'd0));
    end
  endtask

  task automatic finishRun(input string tag);
    model_t e;
    if (q_a.size() == 0 || q_s.size() == 0) begin
      checkOutput({tag, "/scoreboard_entries"}, 32'(q_a.size()), 32'd1);
      return;
    end
    e = q_a.pop_front();
    compareSet(tag, 0, e, 1'b0, 1'b1, e.fc == 16'd0);
    e = q_s.pop_front();
    compareSet(tag, 1, e, 1'b0, 1'b1, e.fc == 16'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    sample = 1'b1;
    num_checks = 32'd9;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    sample = 1'b0;
    clearModel();
    ms = 0;
    mtarget = '0;
  endtask

  task automatic startRun(input logic [31:0] n);
    @(negedge clk);
    start = 1'b1;
    num_checks = n;
    if (ms != 1) begin
      clearModel();
      mtarget = n;
      if (n == 32'd0) begin
        ms = 2;
        q_a.push_back(m[0]);
        q_s.push_back(m[1]);
      end else begin
        ms = 1;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    num_checks = 32'hDEAD_BEEF;
  endtask

  task automatic applyStimulus(input logic [SW-1:0] st, input logic [CH*W-1:0] im, input logic [CH*W-1:0] sp);
    @(negedge clk);
    stim = st;
    impl = im;
    spec = sp;
    sample = 1'b1;
    modelSample(st, im, sp);
    @(posedge clk);
    #1;
    sample = 1'b0;
  endtask

  initial begin
    logic [SW-1:0]   zst;
    logic [CH*W-1:0] rv;
    logic [CH*W-1:0] rs;
    clearModel();
    ms = 0;
    mtarget = '0;

    doReset();
    verifyNow("reset");

    // three clean samples
    startRun(32'd3);
    verifyNow("A_start");
    applyStimulus(24'h000123, 8'h5A, 8'h5A);
    applyStimulus(24'h000456, 8'hC3, 8'hC3);
    applyStimulus(24'h000789, 8'h0F, 8'h0F);
    finishRun("A");

    // impl X tolerated only in approximate mode; spec X demands impl X
    startRun(32'd2);
    applyStimulus(24'h000001, 8'b1x01_0110, 8'b1101_0110);
    applyStimulus(24'h000002, 8'b1001_0011, 8'b1x01_0011);
    finishRun("B");

    startRun(32'd1);
    applyStimulus(24'h000003, 8'b0000_x000, 8'b0000_0000);
    finishRun("C");

    // unknown stimulus on two of four samples, mismatching impl there
    zst = 24'h000000;
    zst[5] = 1'bz;
    startRun(32'd4);
    applyStimulus(zst, 8'hFF, 8'h00);
    applyStimulus(24'h000011, 8'h33, 8'h33);
    applyStimulus(zst, 8'h0F, 8'hF0);
    applyStimulus(24'h000012, 8'h44, 8'h44);
    finishRun("D");

    // known-value failures: lane1 first, then both lanes
    startRun(32'd4);
    applyStimulus(24'h000100, 8'h21, 8'h21);
    applyStimulus(24'h000101, 8'h71, 8'h31);
    applyStimulus(24'h000102, 8'h12, 8'h21);
    applyStimulus(24'h000103, 8'h99, 8'h99);
    verifyNow("E_done");
    finishRun("E");

    // restart from DONE clears counters, busy next cycle
    startRun(32'd3);
    verifyNow("F_restart");
    applyStimulus(24'h000200, 8'h01, 8'h00);
    startRun(32'd1);
    verifyNow("F_start_in_run");
    applyStimulus(24'h000201, 8'h55, 8'h55);
    applyStimulus(24'h000202, 8'h20, 8'h10);
    finishRun("F");

    // random run
    startRun(32'd20);
    for (int i = 0; i < 20; i++) begin
      rv = 8'($urandom);
      rs = ($urandom_range(0, 2) == 0) ? (rv ^ (8'd1 << $urandom_range(0, 7))) : rv;
      applyStimulus(24'($urandom), rv, rs);
    end
    finishRun("G");

    // zero-length run, then a sample in DONE is ignored
    startRun(32'd0);
    finishRun("H");
    applyStimulus(24'h000300, 8'hFF, 8'h00);
    verifyNow("H_sample_in_done");

    // reset mid-run discards everything
    startRun(32'd5);
    applyStimulus(24'h000400, 8'h10, 8'h00);
    applyStimulus(24'h000401, 8'h00, 8'h00);
    doReset();
    verifyNow("I_reset_mid_run");
    applyStimulus(24'h000402, 8'h10, 8'h00);
    verifyNow("I_sample_in_idle");

    // counter saturation
    startRun(32'd70000);
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(24'h000500, 8'h01, 8'h00);
    end
    finishRun("SAT");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
